// File: rtl/wb_arbiter.sv
// Writeback arbiter: two requester FIFOs (ALU, LSU) merged round-robin onto
// a single registered register-file write port. Writes to x0 are dropped.
module wb_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              flush,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              idle
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

   logic [ADDR_W-1:0] q_addr  [2][FIFO_DEPTH];
   logic [DATA_W-1:0] q_data  [2][FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr  [2];
   logic [PTR_W-1:0]  wr_ptr  [2];
   logic [CNT_W-1:0]  count   [2];
   logic [ADDR_W-1:0] in_addr [2];
   logic [DATA_W-1:0] in_data [2];

   logic [1:0]        valid;
   logic [1:0]        ready;
   logic [1:0]        push;
   logic [1:0]        pop;
   logic [1:0]        nonempty;
   logic              last_grant;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign valid      = {req1_valid, req0_valid};
   assign in_addr[0] = req0_addr;
   assign in_addr[1] = req1_addr;
   assign in_data[0] = req0_data;
   assign in_data[1] = req1_data;
   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign idle       = (count[0] == '0) && (count[1] == '0) && !we;

   // Ready deliberately ignores a same-cycle pop so it depends only on state.
   always_comb begin
      nonempty = '0;
      ready    = '0;
      push     = '0;
      for (int i = 0; i < 2; i++) begin
         nonempty[i] = (count[i] != '0);
         ready[i]    = rst_in && (count[i] < FULL);
         push[i]     = valid[i] && ready[i];
      end
   end

   // last_grant=1 means requester 1 was served last, so requester 0 wins a tie.
   always_comb begin
      pop = 2'b00;
      if (nonempty[0] && (!nonempty[1] || last_grant))
         pop[0] = 1'b1;
      else if (nonempty[1])
         pop[1] = 1'b1;
   end

   assign head_addr = pop[1] ? q_addr[1][rd_ptr[1]] : q_addr[0][rd_ptr[0]];
   assign head_data = pop[1] ? q_data[1][rd_ptr[1]] : q_data[0][rd_ptr[0]];

   always_ff @(posedge clk_in) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i] && !flush) begin
            q_addr[i][wr_ptr[i]] <= in_addr[i];
            q_data[i][wr_ptr[i]] <= in_data[i];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int i = 0; i < 2; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         we         <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
         last_grant <= 1'b1;
      end else if (flush) begin
         for (int i = 0; i < 2; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         we <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i])
               wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CNT_W'(1);
               2'b01:   count[i] <= count[i] - CNT_W'(1);
               default: count[i] <= count[i];
            endcase
         end
         if (pop != 2'b00) begin
            last_grant <= pop[1];
            we         <= (head_addr != '0);
            waddr      <= head_addr;
            wdata      <= head_data;
         end else begin
            we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the writeback arbiter.
module tb_wb_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              flush;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic [DATA_W-1:0] req0_data, req1_data;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              idle;

   wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .we(we), .waddr(waddr), .wdata(wdata), .idle(idle)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } entry_t;

   // Reference model: one queue per requester plus who was served last.
   entry_t            mq0[$];
   entry_t            mq1[$];
   int                m_last = 1;
   logic              exp_we = 1'b0;
   logic [ADDR_W-1:0] exp_waddr = '0;
   logic [DATA_W-1:0] exp_wdata = '0;
   bit                acc0, acc1;

   int vectors    = 0;
   int miscompares = 0;

   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkValue("we", we, exp_we);
      checkValue("waddr", waddr, exp_waddr);
      checkValue("wdata", wdata, exp_wdata);
      checkValue("idle", idle, (mq0.size() == 0 && mq1.size() == 0 && !exp_we));
   endtask

   // One clock: drive inputs, check readies, advance model at the edge, check outputs.
   task automatic applyStimulus(input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                                input bit fl, input bit rst);
      bit     r0, r1;
      int     g;
      entry_t e;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      flush = fl; rst_in = rst;
      #1;
      r0 = rst && (mq0.size() < DEPTH);
      r1 = rst && (mq1.size() < DEPTH);
      checkValue("req0_ready", req0_ready, r0);
      checkValue("req1_ready", req1_ready, r1);
      acc0 = v0 && r0;
      acc1 = v1 && r1;
      @(posedge clk_in);
      if (!rst) begin
         mq0.delete(); mq1.delete();
         exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
         m_last = 1;
         acc0 = 0; acc1 = 0;
      end else if (fl) begin
         mq0.delete(); mq1.delete();
         exp_we = 1'b0;
         acc0 = 0; acc1 = 0;
      end else begin
         g = -1;
         if (mq0.size() > 0 && (mq1.size() == 0 || m_last == 1)) g = 0;
         else if (mq1.size() > 0) g = 1;
         if (g == 0) e = mq0.pop_front();
         else if (g == 1) e = mq1.pop_front();
         if (g >= 0) begin
            m_last = g;
            exp_we = (e.a != 0);
            exp_waddr = e.a;
            exp_wdata = e.d;
         end else begin
            exp_we = 1'b0;
         end
         if (acc0) mq0.push_back('{a0, d0});
         if (acc1) mq1.push_back('{a1, d1});
      end
      @(negedge clk_in);
      checkOutput();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
   endtask

   task automatic doReset();
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 0);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 0);
   endtask

   initial begin
      logic [ADDR_W-1:0] ra0, ra1;
      logic [DATA_W-1:0] rd0, rd1;
      bit                rv0, rv1, rfl, rrst;
      int                tries;

      doReset();
      checkValue("reset_we", we, 0);
      checkValue("reset_waddr", waddr, 0);
      checkValue("reset_idle", idle, 1);

      $display("[TB] single push");
      applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, 1);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
      checkValue("single_we", we, 1);
      checkValue("single_waddr", waddr, 5);
      checkValue("single_wdata", wdata, 32'hDEADBEEF);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
      checkValue("single_we_low", we, 0);
      checkValue("single_idle", idle, 1);

      $display("[TB] contention");
      doReset();
      applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
      checkValue("cont_first", waddr, 3);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
      checkValue("cont_second", waddr, 4);
      idleCycles(1);
      applyStimulus(1, 5'd6, 32'h33, 1, 5'd7, 32'h44, 0, 1);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
      checkValue("cont_third", waddr, 6);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
      checkValue("cont_fourth", waddr, 7);
      idleCycles(2);

      $display("[TB] backpressure");
      for (int k = 0; k < 3; k++) begin
         tries = 0;
         do begin
            applyStimulus(1, 5'(10 + tries + 4 * k), 32'h100 + 32'(k * 8 + tries),
                          1, 5'(20 + k), 32'h200 + 32'(k), 0, 1);
            tries++;
         end while (!acc1 && tries < 8);
         checkValue("bp_accept", acc1, 1);
      end
      idleCycles(8);

      $display("[TB] x0 drop");
      applyStimulus(1, 5'd0, 32'hFFFFFFFF, 0, '0, '0, 0, 1);
      applyStimulus(1, 5'd9, 32'h55, 0, '0, '0, 0, 1);
      checkValue("x0_we", we, 0);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
      checkValue("x0_next_we", we, 1);
      checkValue("x0_next_waddr", waddr, 9);
      checkValue("x0_next_wdata", wdata, 32'h55);
      idleCycles(2);

      $display("[TB] flush");
      for (int k = 0; k < 4; k++)
         applyStimulus(1, 5'(1 + k), 32'hA0 + 32'(k), 1, 5'(11 + k), 32'hB0 + 32'(k), 0, 1);
      checkValue("flush_q0_full", req0_ready, 0);
      applyStimulus(1, 5'd30, 32'hEE, 1, 5'd31, 32'hFF, 1, 1);
      checkValue("flush_we", we, 0);
      checkValue("flush_idle", idle, 1);
      checkValue("flush_r0", req0_ready, 1);
      checkValue("flush_r1", req1_ready, 1);
      idleCycles(3);

      $display("[TB] mid-operation reset");
      for (int k = 0; k < 3; k++)
         applyStimulus(1, 5'(2 + k), 32'hC0 + 32'(k), 1, 5'(12 + k), 32'hD0 + 32'(k), 0, 1);
      applyStimulus(1, 5'd8, 32'h99, 1, 5'd9, 32'h98, 1, 0);
      checkValue("rst_we", we, 0);
      checkValue("rst_waddr", waddr, 0);
      checkValue("rst_wdata", wdata, 0);
      checkValue("rst_idle", idle, 1);
      applyStimulus(1, 5'd17, 32'h71, 1, 5'd18, 32'h72, 0, 1);
      applyStimulus(0, '0, '0, 0, '0, '0, 0, 1);
      checkValue("rst_first_grant", waddr, 17);
      idleCycles(3);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         rv0  = ($urandom_range(0, 2) != 0);
         rv1  = ($urandom_range(0, 2) != 0);
         ra0  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ra1  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         rd0  = $urandom;
         rd1  = $urandom;
         rfl  = ($urandom_range(0, 24) == 0);
         rrst = ($urandom_range(0, 49) != 0);
         applyStimulus(rv0, ra0, rd0, rv1, ra1, rd1, rfl, rrst);
      end
      idleCycles(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
